trng_stream_buffer: RTL
=======================

Name: trng_stream_buffer

Overview:
Parametrised output buffer between the TRNG/CPU post-processing path and the external data_out pins. It accepts conditioned random words over a valid/ready handshake and stores them in a DEPTH-entry FIFO. When enable (the board button) is high, it drains one word at a time to a registered data_out, paced by a programmable hold time. It generalises the fixed 32-bit, button-gated output FIFO with configurable width, depth, pacing, overflow mode, level reporting and overflow accounting.

Parameters:
DATA_W, 32, word width in bits (>=8).
DEPTH, 16, FIFO entries; power of 2, >=4.
AFULL_LVL, 14, level at or above which almost_full asserts (1..DEPTH-1).
HOLD_CYC, 4, cycles each presented word is held after its strobe cycle (>=1).
DROP_ON_FULL, 0, 0 = back-pressure producer; 1 = always ready, discard words while full.
REP_LIMIT, 4, consecutive identical accepted words that trip the repetition test (optional feature only, >=2).

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
in_valid  in  1  producer has a word
in_data  in  DATA_W  random word
in_ready  out  1  buffer accepts in_data this cycle
enable  in  1  output enable (button); level-sensitive
data_out  out  DATA_W  last presented word
out_strobe  out  1  one-cycle pulse when data_out updates
full  out  1  level == DEPTH
almost_full  out  1  level >= AFULL_LVL
empty  out  1  level == 0
level  out  $clog2(DEPTH)+1  stored word count
ovf_cnt  out  16  words discarded at full; saturates at 16'hFFFF
rep_fail  out  1  sticky repetition-test failure (0 when feature compiled out)

Behaviour:
- Reset (synchronous, active-high): data_out=0, out_strobe=0, level=0, empty=1, full=0, almost_full=0, ovf_cnt=0, rep_fail=0, pointers=0, FSM=IDLE. A reset asserted mid-hold aborts the hold and flushes the FIFO. Reset wins over every other event.
- in_ready: when DROP_ON_FULL=0, in_ready = !full (taken from registered full). When DROP_ON_FULL=1, in_ready = 1 (forced to 1 during reset).
- Push rule: a push occurs on an edge where in_valid && in_ready && !full. With DROP_ON_FULL=1, in_valid && full discards the word and increments ovf_cnt, even if a pop happens on the same edge.
- Pop/push in the same cycle: level is unchanged. Pointers wrap modulo DEPTH.
- Flags: all flags and level are registered and update on the same edge as the push or pop.
- Output FSM, IDLE: on an edge with enable && !empty, it does the following:
  - data_out <= head word
  - out_strobe <= 1
  - rd_ptr increments
  - cnt <= HOLD_CYC-1
  - state -> HOLD
- Output FSM, HOLD: out_strobe <= 0. If cnt == 0, state -> IDLE; otherwise cnt decrements.
- Throughput: one word per HOLD_CYC+1 cycles while enable is high and the FIFO is non-empty.
- Latency: a word pushed into an empty FIFO at edge N (FSM in IDLE) appears on data_out with out_strobe at edge N+1.
- enable falling during HOLD: the current hold completes and no further pop occurs. data_out retains its value indefinitely; it never returns to 0 except on reset.
- enable high with an empty FIFO: the FSM stays in IDLE and data_out is unchanged.

Optional Feature:
TRNG_REPCOUNT_EN:
- Defined: the block tracks a last-accepted word register and a run counter. Each push equal to the previous pushed word increments the run; a different word resets the run to 1.
- When the run reaches REP_LIMIT, rep_fail sets and stays set until reset. While rep_fail=1, the FSM does not leave IDLE (output frozen), but the FIFO still accepts words.
- Not defined: rep_fail is tied to 0 and no compare logic is built.

Decomposition:
- Package trng_pkg: output FSM state encoding (IDLE, HOLD), OVF_W=16, and a clog2-based LEVEL_W helper constant.
- Sub-module trng_sync_fifo(DATA_W, DEPTH): memory, pointers, level and flags, with push/pop inputs.
- trng_stream_buffer contains the handshake, drop/ovf logic, output FSM and the optional repetition test.

Test Plan:
1. Reset, then push 0xA5A5_0001..0xA5A5_0003 with enable=1, HOLD_CYC=4 -> strobes 5 cycles apart, data_out in order, level returns to 0, empty=1.
2. enable=0, push 16 words, DROP_ON_FULL=0 -> full=1 and in_ready=0 after the 16th word; almost_full=1 from the 14th; the 17th word is held off and is accepted after the first pop once enable=1.
3. DROP_ON_FULL=1, enable=0, push 20 words -> level=16, ovf_cnt=4, in_ready stays 1; draining yields words 1..16 only.
4. enable dropped 2 cycles after a strobe -> hold finishes, no further strobe, data_out stable; re-asserting enable resumes with the next word.
5. Assert rst during HOLD with 5 words stored -> next edge: data_out=0, level=0, empty=1, FSM in IDLE, no strobe.
6. TRNG_REPCOUNT_EN defined, REP_LIMIT=4: push 0xDEAD_BEEF four times -> rep_fail=1 after the 4th push, out_strobe stays 0; a different word afterwards keeps rep_fail=1 until rst.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG output stream buffer.
// Optional repetition test is enabled by defining TRNG_REPCOUNT_EN.
package trng_pkg;

  typedef enum logic {
    IDLE,
    HOLD
  } out_state_t;

  localparam int OVF_W = 16;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock FIFO with registered level and status flags.
// Callers never push when full or pop when empty.
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        almost_full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_n;

  assign rdata = mem[rd_ptr];

  always_comb begin
    level_n = level;
    if (push && !pop)
      level_n = level + LW'(1);
    else if (pop && !push)
      level_n = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      empty       <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level       <= level_n;
      full        <= (level_n == LW'(DEPTH));
      almost_full <= (level_n >= LW'(AFULL_LVL));
      empty       <= (level_n == '0);
    end
  end

endmodule

// File: rtl/trng_stream_buffer.sv
// Paced, button-gated output buffer for conditioned TRNG words.
// Define TRNG_REPCOUNT_EN to build the repetition-count health test.
module trng_stream_buffer
  import trng_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_LVL    = 14,
  parameter int HOLD_CYC     = 4,
  parameter int DROP_ON_FULL = 0,
  parameter int REP_LIMIT    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      enable,
  output logic [DATA_W-1:0]         data_out,
  output logic                      out_strobe,
  output logic                      full,
  output logic                      almost_full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level,
  output logic [OVF_W-1:0]          ovf_cnt,
  output logic                      rep_fail
);

  localparam int CW = $clog2(HOLD_CYC + 1);

  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] head;
  out_state_t        state;
  out_state_t        state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [DATA_W-1:0] data_n;
  logic              strobe_n;

  assign in_ready = (DROP_ON_FULL != 0) ? 1'b1 : !full;
  assign push     = in_valid && in_ready && !full;
  assign drop     = (DROP_ON_FULL != 0) && in_valid && full;

  trng_sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .wdata       (in_data),
    .rdata       (head),
    .level       (level),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty)
  );

  always_ff @(posedge clk) begin
    if (rst)
      ovf_cnt <= '0;
    else if (drop && ovf_cnt != '1)
      ovf_cnt <= ovf_cnt + OVF_W'(1);
  end

`ifdef TRNG_REPCOUNT_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [DATA_W-1:0] last;
  logic [RW-1:0]     run;

  // run == 0 means no word has been accepted since reset
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= '0;
      run      <= '0;
      rep_fail <= 1'b0;
    end else if (push) begin
      last <= in_data;
      if (run != '0 && in_data == last) begin
        if (run != RW'(REP_LIMIT))
          run <= run + RW'(1);
        if (run >= RW'(REP_LIMIT - 1))
          rep_fail <= 1'b1;
      end else begin
        run <= RW'(1);
      end
    end
  end
`else
  assign rep_fail = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    data_n   = data_out;
    strobe_n = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !empty && !rep_fail) begin
          pop      = 1'b1;
          data_n   = head;
          strobe_n = 1'b1;
          cnt_n    = CW'(HOLD_CYC - 1);
          state_n  = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0)
          state_n = IDLE;
        else
          cnt_n = cnt - CW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_out   <= '0;
      out_strobe <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_out   <= data_n;
      out_strobe <= strobe_n;
    end
  end

endmodule
